// File: rtl/tm1637_writer.sv
// TM1637 two-wire transmitter: frames handshaked bytes into START, LSB-first
// data bits with an ACK slot, and STOP, driving CLK and open-drain DIO.
module tm1637_writer #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       tm_clk,
    output logic       tm_dio_oe,
    input  logic       tm_dio_in
);

    localparam int unsigned TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_BIT_LO,
        S_BIT_HI,
        S_ACK_LO,
        S_ACK_HI,
        S_WAIT,
        S_STOP_LO,
        S_STOP_HI,
        S_STOP_REL
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic          r_last;
    logic          w_last_nx;
    logic          w_tick_end;
    logic          w_accept;
    logic          w_clk_nx;
    logic          w_oe_nx;

    assign w_tick_end = (r_tick == TW'(CLK_DIV - 1));
    assign w_accept   = cmd_valid & cmd_ready;

    always_comb begin
        w_state_nx = r_state;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_last_nx  = r_last;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_START;
                    w_shift_nx = cmd_data;
                    w_last_nx  = cmd_last;
                    w_bit_nx   = '0;
                end
            end
            S_START: begin
                if (w_tick_end) begin
                    w_state_nx = S_BIT_LO;
                    w_bit_nx   = '0;
                end
            end
            S_BIT_LO: begin
                if (w_tick_end) w_state_nx = S_BIT_HI;
            end
            S_BIT_HI: begin
                if (w_tick_end) begin
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_ACK_LO;
                    end else begin
                        w_state_nx = S_BIT_LO;
                        w_bit_nx   = r_bit + 3'd1;
                    end
                end
            end
            S_ACK_LO: begin
                if (w_tick_end) w_state_nx = S_ACK_HI;
            end
            S_ACK_HI: begin
                if (w_tick_end) w_state_nx = r_last ? S_STOP_LO : S_WAIT;
            end
            S_WAIT: begin
                if (w_accept) begin
                    w_state_nx = S_BIT_LO;
                    w_shift_nx = cmd_data;
                    w_last_nx  = cmd_last;
                    w_bit_nx   = '0;
                end
            end
            S_STOP_LO: begin
                if (w_tick_end) w_state_nx = S_STOP_HI;
            end
            S_STOP_HI: begin
                if (w_tick_end) w_state_nx = S_STOP_REL;
            end
            S_STOP_REL: begin
                if (w_tick_end) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Pin levels are decoded from the next state so the registered pins
        // change on the same edge as the state itself.
        w_clk_nx = 1'b1;
        w_oe_nx  = 1'b0;
        case (w_state_nx)
            S_IDLE:     begin w_clk_nx = 1'b1; w_oe_nx = 1'b0;           end
            S_START:    begin w_clk_nx = 1'b1; w_oe_nx = 1'b1;           end
            S_BIT_LO:   begin w_clk_nx = 1'b0; w_oe_nx = ~w_shift_nx[0]; end
            S_BIT_HI:   begin w_clk_nx = 1'b1; w_oe_nx = ~w_shift_nx[0]; end
            S_ACK_LO:   begin w_clk_nx = 1'b0; w_oe_nx = 1'b0;           end
            S_ACK_HI:   begin w_clk_nx = 1'b1; w_oe_nx = 1'b0;           end
            S_WAIT:     begin w_clk_nx = 1'b0; w_oe_nx = 1'b0;           end
            S_STOP_LO:  begin w_clk_nx = 1'b0; w_oe_nx = 1'b1;           end
            S_STOP_HI:  begin w_clk_nx = 1'b1; w_oe_nx = 1'b1;           end
            S_STOP_REL: begin w_clk_nx = 1'b1; w_oe_nx = 1'b0;           end
            default:    begin w_clk_nx = 1'b1; w_oe_nx = 1'b0;           end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_last    <= 1'b0;
            tm_clk    <= 1'b1;
            tm_dio_oe <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_last  <= w_last_nx;

            if (w_state_nx != r_state) begin
                r_tick <= '0;
            end else if (r_state != S_IDLE && r_state != S_WAIT) begin
                r_tick <= r_tick + 1'b1;
            end

            tm_clk    <= w_clk_nx;
            tm_dio_oe <= w_oe_nx;
            cmd_ready <= (w_state_nx == S_IDLE) || (w_state_nx == S_WAIT);
            busy      <= (w_state_nx != S_IDLE);
            done      <= (r_state == S_STOP_REL) && w_tick_end;
            ack_err   <= (r_state == S_ACK_HI) && w_tick_end && tm_dio_in;
        end
    end

endmodule
